// File: rtl/gameconsole_pkg.sv
// Shared types and video memory map for the game console fabric.
// Requester ids, arbiter states and return-pipeline entry live here.
package gameconsole_pkg;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DMA = 1'b1
  } req_id_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic    valid;
    req_id_e owner;
  } ret_t;

  localparam logic [31:0] VMEM_PARAM_BASE = 32'h0600_0000;
  localparam logic [31:0] VMEM_MAP_BASE   = 32'h0610_0000;
  localparam logic [31:0] VMEM_TILE_BASE  = 32'h0620_0000;
  localparam logic [31:0] VMEM_PAL_BASE   = 32'h0630_0000;

endpackage

// File: rtl/vmem_arbiter.sv
// Two-port video memory arbiter: CPU and DMA share one memory port.
// Burst-limited ownership with round-robin tie break from idle.
module vmem_arbiter
  import gameconsole_pkg::*;
#(
  parameter int unsigned BURST_MAX = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r0_req,
  input  logic        r0_we,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  output logic        r0_gnt,
  output logic        r0_rvalid,
  output logic [31:0] r0_rdata,
  input  logic        r1_req,
  input  logic        r1_we,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  output logic        r1_gnt,
  output logic        r1_rvalid,
  output logic [31:0] r1_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  localparam logic [7:0] BMAX = 8'(BURST_MAX);

  arb_state_e state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic       rr_last;
  logic       gnt0, gnt1;
  logic       at_max;
  logic       xfer;
  logic       sel_we;
  logic [31:0] sel_addr, sel_wdata;
  ret_t       ret_q [2];

  assign at_max = (cnt >= BMAX);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      unique case (state)
        ST_OWN0: begin
          if (r0_req && !(at_max && r1_req)) gnt0 = 1'b1;
          else if (r1_req)                   gnt1 = 1'b1;
        end
        ST_OWN1: begin
          if (r1_req && !(at_max && r0_req)) gnt1 = 1'b1;
          else if (r0_req)                   gnt0 = 1'b1;
        end
        default: begin
          if (r0_req && (!r1_req || rr_last)) gnt0 = 1'b1;
          else if (r1_req)                    gnt1 = 1'b1;
        end
      endcase
    end
  end

  // Staying with the same owner extends the burst; a new owner restarts it.
  always_comb begin
    state_nx = ST_IDLE;
    cnt_nx   = 8'd0;
    if (gnt0) begin
      state_nx = ST_OWN0;
      cnt_nx   = (state != ST_OWN0) ? 8'd1 :
                 at_max ? cnt : cnt + 8'd1;
    end else if (gnt1) begin
      state_nx = ST_OWN1;
      cnt_nx   = (state != ST_OWN1) ? 8'd1 :
                 at_max ? cnt : cnt + 8'd1;
    end
  end

  assign r0_gnt    = gnt0;
  assign r1_gnt    = gnt1;
  assign xfer      = gnt0 | gnt1;
  assign sel_we    = gnt1 ? r1_we    : r0_we;
  assign sel_addr  = gnt1 ? r1_addr  : r0_addr;
  assign sel_wdata = gnt1 ? r1_wdata : r0_wdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= 8'd0;
      rr_last  <= 1'b1;
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= 32'd0;
      mem_din  <= 32'd0;
      ret_q[0] <= '0;
      ret_q[1] <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      mem_en   <= xfer;
      mem_we   <= xfer & sel_we;
      if (xfer) begin
        rr_last  <= gnt1;
        mem_addr <= sel_addr;
        mem_din  <= sel_wdata;
      end
      ret_q[0].valid <= xfer & ~sel_we;
      ret_q[0].owner <= gnt1 ? REQ_DMA : REQ_CPU;
      ret_q[1]       <= ret_q[0];
    end
  end

  // Memory answers one cycle after the command, so the tail stage
  // lines up with mem_dout.
  assign r0_rvalid = ret_q[1].valid && (ret_q[1].owner == REQ_CPU);
  assign r1_rvalid = ret_q[1].valid && (ret_q[1].owner == REQ_DMA);
  assign r0_rdata  = r0_rvalid ? mem_dout : 32'd0;
  assign r1_rdata  = r1_rvalid ? mem_dout : 32'd0;

endmodule

// File: tb/tb_vmem_arbiter.sv
// Bench for vmem_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level arbitration model.
module tb_vmem_arbiter;
  import gameconsole_pkg::*;

  localparam int BM = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        r0_req = 1'b0, r0_we = 1'b0;
  logic [31:0] r0_addr = '0, r0_wdata = '0;
  logic        r0_gnt, r0_rvalid;
  logic [31:0] r0_rdata;
  logic        r1_req = 1'b0, r1_we = 1'b0;
  logic [31:0] r1_addr = '0, r1_wdata = '0;
  logic        r1_gnt, r1_rvalid;
  logic [31:0] r1_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_din;
  logic [31:0] mem_dout = '0;

  int n_checks = 0;
  int n_errors = 0;
  logic started = 1'b0;
  logic g0, g1;

  always #5 clk = ~clk;

  vmem_arbiter #(.BURST_MAX(BM)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_we(r0_we),
    .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid),
    .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we),
    .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid),
    .r1_rdata(r1_rdata),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  function automatic int ix(logic [31:0] a);
    return int'({a[21:20], a[2:0]});
  endfunction

  // Video memory device: unwritten words read back their low address half.
  logic [31:0] dev [32];
  logic [31:0] dev_w = '0;
  always @(posedge clk) begin
    if (mem_en === 1'b1) begin
      if (mem_we) begin
        dev[ix(mem_addr)]   <= mem_din;
        dev_w[ix(mem_addr)] <= 1'b1;
      end else begin
        mem_dout <= dev_w[ix(mem_addr)] ? dev[ix(mem_addr)]
                                        : {16'h0, mem_addr[15:0]};
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the port, how long the current run is,
  // who was served last, and what each transfer must produce.
  int          m_owner, m_run, m_last;
  logic [31:0] mm [32];
  logic [31:0] mm_w = '0;
  logic        exp_en, exp_we;
  logic [31:0] exp_addr, exp_din;
  logic        pa_v, pb_v;
  int          pa_o, pb_o;
  logic [31:0] pa_d, pb_d;

  function automatic int arb(logic q0, logic q1);
    logic mine, other;
    if (!rst_n) return -1;
    if (m_owner >= 0) begin
      mine  = (m_owner == 0) ? q0 : q1;
      other = (m_owner == 0) ? q1 : q0;
      if (mine && !(m_run >= BM && other)) return m_owner;
      if (other) return 1 - m_owner;
      return -1;
    end
    if (q0 && q1) return 1 - m_last;
    if (q0) return 0;
    if (q1) return 1;
    return -1;
  endfunction

  always @(posedge clk) begin : model
    int g;
    logic w;
    logic [31:0] a, d;
    if (!rst_n) begin
      m_owner <= -1; m_run <= 0; m_last <= 1;
      exp_en <= 1'b0; exp_we <= 1'b0;
      exp_addr <= '0; exp_din <= '0;
      pa_v <= 1'b0; pb_v <= 1'b0;
      pa_o <= 0; pb_o <= 0; pa_d <= '0; pb_d <= '0;
    end else begin
      g = arb(r0_req, r1_req);
      pb_v <= pa_v; pb_o <= pa_o; pb_d <= pa_d;
      if (g < 0) begin
        m_owner <= -1; m_run <= 0;
        exp_en <= 1'b0; exp_we <= 1'b0; pa_v <= 1'b0;
      end else begin
        w = (g == 0) ? r0_we : r1_we;
        a = (g == 0) ? r0_addr : r1_addr;
        d = (g == 0) ? r0_wdata : r1_wdata;
        exp_en <= 1'b1; exp_we <= w;
        exp_addr <= a; exp_din <= d;
        pa_v <= !w; pa_o <= g;
        pa_d <= mm_w[ix(a)] ? mm[ix(a)] : {16'h0, a[15:0]};
        if (w) begin
          mm[ix(a)]   <= d;
          mm_w[ix(a)] <= 1'b1;
        end
        m_run <= (g == m_owner) ? ((m_run >= BM) ? BM : m_run + 1) : 1;
        m_owner <= g;
        m_last <= g;
      end
    end
  end

  always @(negedge clk) begin : compare
    int g;
    if (started) begin
      g = arb(r0_req, r1_req);
      chk("r0_gnt", 32'(r0_gnt), 32'(g == 0));
      chk("r1_gnt", 32'(r1_gnt), 32'(g == 1));
      chk("mem_en", 32'(mem_en), 32'(exp_en));
      chk("mem_we", 32'(mem_we), 32'(exp_we));
      if (exp_en) begin
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_din", mem_din, exp_din);
      end
      chk("r0_rvalid", 32'(r0_rvalid), 32'(pb_v && pb_o == 0));
      chk("r1_rvalid", 32'(r1_rvalid), 32'(pb_v && pb_o == 1));
      if (pb_v && pb_o == 0) chk("r0_rdata", r0_rdata, pb_d);
      if (pb_v && pb_o == 1) chk("r1_rdata", r1_rdata, pb_d);
    end
  end

  task automatic step();
    #8;
    g0 = r0_gnt;
    g1 = r1_gnt;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] raddr();
    logic [31:0] b;
    case ($urandom_range(0, 3))
      0: b = VMEM_PARAM_BASE;
      1: b = VMEM_MAP_BASE;
      2: b = VMEM_TILE_BASE;
      default: b = VMEM_PAL_BASE;
    endcase
    return b | 32'($urandom_range(0, 7));
  endfunction

  task automatic new0(logic want);
    r0_req = want; r0_we = 1'($urandom_range(0, 1));
    r0_addr = raddr(); r0_wdata = $urandom;
  endtask

  task automatic new1(logic want);
    r1_req = want; r1_we = 1'($urandom_range(0, 1));
    r1_addr = raddr(); r1_wdata = $urandom;
  endtask

  // Requests are held high through reset to prove grants stay low.
  task automatic do_reset();
    rst_n = 1'b0;
    r0_req = 1'b1; r1_req = 1'b1;
    step();
    chk("rst_gnt", {30'd0, g0, g1}, 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    r0_req = 1'b0; r1_req = 1'b0;
    rst_n = 1'b1;
  endtask

  int seq [10];
  int exp28 [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
  int n0, n1;

  initial begin
    @(posedge clk);
    #1;
    started = 1'b1;
    do_reset();

    r0_req = 1'b1; r0_we = 1'b1;
    r0_addr = VMEM_PAL_BASE | 32'h1; r0_wdata = 32'hFF00_00FF;
    step();
    chk("w_gnt0", 32'(g0), 32'd1);
    chk("w_gnt1", 32'(g1), 32'd0);
    r0_req = 1'b0;
    chk("w_mem_en", 32'(mem_en), 32'd1);
    chk("w_mem_we", 32'(mem_we), 32'd1);
    chk("w_mem_addr", mem_addr, 32'h0630_0001);
    chk("w_mem_din", mem_din, 32'hFF00_00FF);
    step();

    r1_req = 1'b1; r1_we = 1'b0; r1_addr = VMEM_MAP_BASE | 32'h5;
    step();
    chk("rd_gnt1", 32'(g1), 32'd1);
    r1_req = 1'b0;
    step();
    chk("rd_r1_rvalid", 32'(r1_rvalid), 32'd1);
    chk("rd_r1_rdata", r1_rdata, 32'h0000_0005);
    chk("rd_r0_rvalid", 32'(r0_rvalid), 32'd0);
    step();

    for (int j = 0; j < 7; j++) begin
      r0_req = 1'b0; r1_req = 1'b0;
      if (j < 6) begin
        if (j % 2 == 0) begin
          r0_req = 1'b1; r0_we = 1'b0; r0_addr = raddr();
        end else begin
          r1_req = 1'b1; r1_we = 1'b0; r1_addr = raddr();
        end
      end
      step();
      if (j < 6) chk("alt_gnt", {30'd0, g1, g0}, (j % 2 == 0) ? 32'd1 : 32'd2);
      if (j >= 1) begin
        chk("alt_rv0", 32'(r0_rvalid), 32'((j - 1) % 2 == 0));
        chk("alt_rv1", 32'(r1_rvalid), 32'((j - 1) % 2 == 1));
      end
    end

    do_reset();
    new0(1'b1); new1(1'b1);
    for (int i = 0; i < 10; i++) begin
      step();
      seq[i] = g0 ? 0 : (g1 ? 1 : -1);
      if (g0) new0(1'b1);
      if (g1) new1(1'b1);
    end
    for (int i = 0; i < 10; i++) chk("burst_seq", 32'(seq[i]), 32'(exp28[i]));
    r0_req = 1'b0; r1_req = 1'b0;
    step();

    do_reset();
    n0 = 0; n1 = 0;
    new1(1'b1);
    for (int i = 0; i < 40; i++) begin
      step();
      n0 += int'(g0); n1 += int'(g1);
      if (g1) new1(1'b1);
    end
    chk("solo_grants", 32'(n1), 32'd40);
    chk("solo_other", 32'(n0), 32'd0);
    new0(1'b1);
    step();
    chk("sat_switch", {30'd0, g1, g0}, 32'd1);
    r0_req = 1'b0; r1_req = 1'b0;
    step();

    do_reset();
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = raddr();
    step();
    chk("rr_gnt0", 32'(g0), 32'd1);
    r0_req = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rr_mem_en", 32'(mem_en), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("rr_rv", {30'd0, r1_rvalid, r0_rvalid}, 32'd0);
      step();
    end

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (!r0_req || g0) new0($urandom_range(0, 9) < 6);
      if (!r1_req || g1) new1($urandom_range(0, 9) < 6);
      rst_n = ($urandom_range(0, 499) != 0);
      step();
      if (!rst_n) begin
        g0 = 1'b0; g1 = 1'b0;
      end
    end
    rst_n = 1'b1;
    r0_req = 1'b0; r1_req = 1'b0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vmem_arbiter.md
VMEM_ARBITER -- requirements
Module: vmem_arbiter

Interface
REQ-001 SHALL have parameter BURST_MAX, default 16, meaning max consecutive grants to one requester while the other waits (range 1..255).
REQ-002 SHALL have port clk, input, 1, clock.
REQ-003 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-004 SHALL have ports r0_req/r0_we, input, 1 each, requester 0 (CPU) request and write-enable.
REQ-005 SHALL have ports r0_addr/r0_wdata, input, 32 each, requester 0 word address and write data.
REQ-006 SHALL have ports r0_gnt/r0_rvalid, output, 1 each, and r0_rdata, output, 32: accept, read-data-valid, read data.
REQ-007 SHALL have identical r1_* ports for requester 1 (DMA).
REQ-008 SHALL have ports mem_en/mem_we, output, 1 each, and mem_addr/mem_din, output, 32 each: video memory command.
REQ-009 SHALL have port mem_dout, input, 32, memory read data, valid exactly 1 cycle after a read command.

Function
REQ-010 Handshake SHALL be: requester holds req, we, addr, wdata stable until the cycle rN_gnt=1; a transfer occurs in any cycle with req=1 and gnt=1.
REQ-011 rN_gnt SHALL be combinational from the current req inputs and registered state; at most one gnt high per cycle.
REQ-012 A transfer in cycle T SHALL drive mem_en=1, mem_we, mem_addr, mem_din from the granted requester, registered, in cycle T+1; with no transfer, mem_en=0 and mem_we=0 in T+1.
REQ-013 A read transfer in cycle T SHALL give rN_rvalid=1 with rN_rdata=mem_dout to its owner in cycle T+2 only; other requester's rvalid stays 0.
REQ-014 Back-to-back transfers (one per cycle) SHALL be supported with no bubbles, reads and writes freely interleaved.
REQ-015 FSM states SHALL be IDLE, OWN0, OWN1; owner is the requester granted most recently within a burst.
REQ-016 IDLE: if only one req, grant it and go to its OWN state; if both, grant the requester not marked by rr_last (rr_last resets to 1, so requester 0 wins first).
REQ-017 OWNn: grant n while rn_req=1 and burst count < BURST_MAX; increment 8-bit burst count per grant.
REQ-018 OWNn: if rn_req=0, or count = BURST_MAX and other req=1, grant the other requester in the same cycle if it requests (move to its OWN state, count=1), else go IDLE.
REQ-019 Count reaching BURST_MAX with the other requester idle SHALL NOT switch ownership; count saturates at BURST_MAX.
REQ-020 rr_last SHALL update to the granted requester on every transfer.
REQ-021 rdata return tracking SHALL use a 2-stage pipeline of {valid, owner} per transfer.

Reset
REQ-022 With rst_n=0 at a clk edge: state=IDLE, count=0, rr_last=1, mem_en=0, mem_we=0, mem_addr=0, mem_din=0, rN_rvalid=0, rN_rdata=0, return pipeline cleared.
REQ-023 During reset all rN_gnt SHALL be 0.
REQ-024 Reads in flight at reset SHALL be discarded; no rvalid after reset release for pre-reset transfers.

Structure
REQ-025 gameconsole_pkg SHALL hold the requester-id enum (REQ_CPU=0, REQ_DMA=1), the FSM state enum, and video memory base constants (param 0x0600_0000, map 0x0610_0000, tile 0x0620_0000, palette 0x0630_0000).
REQ-026 Single module, no sub-module; the rdata return pipeline is inline.

Verification
REQ-027 Reset, then r0 write addr 0x0630_0001 data 0xFF0000FF alone -> r0_gnt same cycle; next cycle mem_en=1, mem_we=1, mem_addr=0x0630_0001, mem_din=0xFF0000FF.
REQ-028 Both req continuously from IDLE, BURST_MAX=4 -> grants 0,0,0,0,1,1,1,1,0,... with no idle cycles.
REQ-029 r1 read 0x0610_0005 with model returning 0x0000_0005 -> r1_rvalid=1, r1_rdata=5 two cycles after grant; r0_rvalid stays 0.
REQ-030 r1 alone for 40 cycles, BURST_MAX=16 -> 40 consecutive grants, no ownership switch, count holds 16.
REQ-031 Alternating r0 read, r1 read back-to-back -> rvalid returns in order to correct owners with matching data.
REQ-032 rst_n=0 one cycle after a read grant -> no rvalid on either port after reset; mem_en=0 on the first cycle after reset.
